regfile_write_stage: RTL and testbench

Write side of the 32 x 32-bit register file, directly upstream of the read ports. It accepts register writes through a valid/ready handshake and buffers them in a small FIFO. It commits one write per cycle into the register array unless commits are held. It drives the flat 1024-bit `registers_out` bus that every read port consumes, plus a pending-write mask for hazard checks.

---
 rtl/regfile_write_stage_pkg.sv | 15 +
 rtl/regfile_write_stage_if.sv | 10 +
 rtl/regfile_write_stage_write_fifo.sv | 54 +++++
 rtl/regfile_write_stage.sv | 61 ++++++
 tb/tb_regfile_write_stage.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/regfile_write_stage_pkg.sv
// regfile_write_stage_pkg: shared register-file sizes, write-entry type and index decoder
package regfile_write_stage_pkg;
  localparam int REG_COUNT = 32;
  localparam int REG_WIDTH = 32;
  localparam int REG_IDX_W = 5;

  typedef struct packed {
    logic [REG_IDX_W-1:0] index;
    logic [REG_WIDTH-1:0] data;
  } wr_entry_t;

  function automatic logic [REG_COUNT-1:0] decode_idx(input logic [REG_IDX_W-1:0] idx);
    return REG_COUNT'(1) << idx;
  endfunction
endpackage

// File: rtl/regfile_write_stage_if.sv
// regfile_write_stage_if: valid/ready register-write request channel
interface regfile_write_stage_if;
  import regfile_write_stage_pkg::*;
  logic                 wr_valid;
  logic                 wr_ready;
  logic [REG_IDX_W-1:0] ctrl_writeReg;
  logic [REG_WIDTH-1:0] data_writeReg;
  modport master (output wr_valid, ctrl_writeReg, data_writeReg, input wr_ready);
  modport slave (input wr_valid, ctrl_writeReg, data_writeReg, output wr_ready);
endinterface

// File: rtl/regfile_write_stage_write_fifo.sv
// write_fifo: in-order write buffer exposing per-entry indices and valids
module write_fifo
  import regfile_write_stage_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = wr_entry_t
) (
  input  logic                 clock,
  input  logic                 ctrl_reset_n,
  input  logic                 push,
  input  logic                 pop,
  input  entry_t               din,
  output entry_t               head,
  output logic                 full,
  output logic                 empty,
  output logic [REG_IDX_W-1:0] ent_idx [DEPTH],
  output logic [DEPTH-1:0]     ent_valid
);
  localparam int PW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0]   cnt;

  assign full  = cnt == (PW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign head  = mem[rp];

  // Pointers wrap naturally at DEPTH; reset discards all buffered entries
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop) rp <= rp + PW'(1);
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // Entry storage needs no reset: validity comes from the pointers
  always_ff @(posedge clock) begin
    if (push) mem[wp] <= din;
  end

  // An entry is live when its distance from the read pointer is below occupancy
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic [PW-1:0] off;
    assign off          = PW'(g) - rp;
    assign ent_valid[g] = {1'b0, off} < cnt;
    assign ent_idx[g]   = mem[g].index;
  end
endmodule

// File: rtl/regfile_write_stage.sv
// regfile_write_stage: buffered write side of the 32x32 register file
module regfile_write_stage
  import regfile_write_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                           clock,
  input  logic                           ctrl_reset_n,
  regfile_write_stage_if.slave           wr,
  input  logic                           ctrl_hold,
  output logic [REG_COUNT*REG_WIDTH-1:0] registers_out,
  output logic                           wr_pending,
  output logic [REG_COUNT-1:0]           pending_mask
);
  logic                 full, empty, push, pop;
  wr_entry_t            din, head;
  logic [REG_IDX_W-1:0] ent_idx [DEPTH];
  logic [DEPTH-1:0]     ent_valid;
  logic [REG_COUNT-1:0] we;
  logic [REG_WIDTH-1:0] regs [REG_COUNT];

  assign wr.wr_ready = !full;
  assign push        = wr.wr_valid && !full && wr.ctrl_writeReg != '0;
  assign pop         = !empty && !ctrl_hold;
  assign din         = {wr.ctrl_writeReg, wr.data_writeReg};
  assign wr_pending  = !empty;
  assign we          = pop ? decode_idx(head.index) : '0;

  write_fifo #(.DEPTH(DEPTH), .entry_t(wr_entry_t)) u_fifo (
    .clock(clock),
    .ctrl_reset_n(ctrl_reset_n),
    .push(push),
    .pop(pop),
    .din(din),
    .head(head),
    .full(full),
    .empty(empty),
    .ent_idx(ent_idx),
    .ent_valid(ent_valid)
  );

  // Commit the FIFO head into the array; register 0 is never written
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) if (we[i] && i != 0) regs[i] <= head.data;
    end
  end

  // Union of all buffered destination registers for hazard checks
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) if (ent_valid[i]) pending_mask = pending_mask | decode_idx(ent_idx[i]);
    pending_mask[0] = 1'b0;
  end

  for (genvar g = 0; g < REG_COUNT; g++) begin : g_pack
    assign registers_out[REG_WIDTH*g +: REG_WIDTH] = g == 0 ? '0 : regs[g];
  end
endmodule

// File: tb/tb_regfile_write_stage.sv
// tb_regfile_write_stage: randomized scoreboard bench against a queue-based register-file model
module tb_regfile_write_stage;
  import regfile_write_stage_pkg::*;
  localparam int DEPTH = 2;

  logic          clock = 1'b0;
  logic          ctrl_reset_n = 1'b0;
  logic          ctrl_hold = 1'b0;
  logic [1023:0] registers_out;
  logic          wr_pending;
  logic [31:0]   pending_mask;

  regfile_write_stage_if wr();

  regfile_write_stage #(.DEPTH(DEPTH)) dut (
    .clock(clock),
    .ctrl_reset_n(ctrl_reset_n),
    .wr(wr),
    .ctrl_hold(ctrl_hold),
    .registers_out(registers_out),
    .wr_pending(wr_pending),
    .pending_mask(pending_mask)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1023:0] regs;
    logic [31:0]   mask;
    logic          pend;
    logic          rdy;
  } exp_t;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
  } ent_t;

  exp_t        expq[$];
  ent_t        mq[$];
  logic [31:0] mregs[32];
  int          checks = 0;
  int          fails = 0;

  task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.regs = '0;
    e.mask = '0;
    for (int i = 0; i < 32; i++) e.regs[32*i +: 32] = mregs[i];
    foreach (mq[k]) e.mask[mq[k].idx] = 1'b1;
    e.pend = mq.size() != 0;
    e.rdy  = mq.size() < DEPTH;
    return e;
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_regs"}, registers_out, '0);
    chk({tag, "_mask"}, 1024'(pending_mask), '0);
    chk({tag, "_pending"}, 1024'(wr_pending), '0);
    chk({tag, "_ready"}, 1024'(wr.wr_ready), 1024'(1));
  endtask

  // One clock cycle of stimulus; the model predicts the state after the coming edge
  task automatic cycle(input logic v, input logic [4:0] idx, input logic [31:0] d,
                       input logic h, input logic r, output logic acc);
    ent_t e;
    @(negedge clock);
    if (r) begin
      #1 ctrl_reset_n = 1'b0;
      #1 check_reset_outputs("mid_reset");
      model_reset();
      #1 ctrl_reset_n = 1'b1;
    end
    wr.wr_valid      = v;
    wr.ctrl_writeReg = idx;
    wr.data_writeReg = d;
    ctrl_hold        = h;
    acc = v && mq.size() < DEPTH;
    if (!h && mq.size() > 0) begin
      e = mq.pop_front();
      mregs[e.idx] = e.data;
    end
    if (acc && idx != 0) mq.push_back('{idx, d});
    expq.push_back(snap());
  endtask

  // Monitor: after each edge, compare the DUT against the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("registers_out", registers_out, e.regs);
        chk("pending_mask", 1024'(pending_mask), 1024'(e.mask));
        chk("wr_pending", 1024'(wr_pending), 1024'(e.pend));
        chk("wr_ready", 1024'(wr.wr_ready), 1024'(e.rdy));
      end
    end
  end

  initial begin
    logic        a;
    logic        have;
    logic [4:0]  ridx;
    logic [31:0] rdat;
    wr.wr_valid      = 1'b0;
    wr.ctrl_writeReg = '0;
    wr.data_writeReg = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1 check_reset_outputs("reset");
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    cycle(1, 5'd5, 32'hDEADBEEF, 0, 0, a);
    cycle(0, 5'd0, 32'h0, 0, 0, a);
    cycle(1, 5'd0, 32'hFFFFFFFF, 0, 0, a);
    cycle(0, 5'd0, 32'h0, 0, 0, a);
    cycle(1, 5'd1, 32'h11, 1, 0, a);
    cycle(1, 5'd2, 32'h22, 1, 0, a);
    cycle(1, 5'd9, 32'h99, 1, 0, a);
    cycle(1, 5'd9, 32'h99, 0, 0, a);
    chk("full_pop_no_accept", 1024'(a), '0);
    cycle(1, 5'd9, 32'h99, 1, 0, a);
    chk("accept_after_pop", 1024'(a), 1024'(1));
    cycle(0, 5'd0, 32'h0, 1, 0, a);
    repeat (3) cycle(0, 5'd0, 32'h0, 0, 0, a);
    cycle(1, 5'd7, 32'hA, 0, 0, a);
    cycle(1, 5'd7, 32'hB, 0, 0, a);
    repeat (2) cycle(0, 5'd0, 32'h0, 0, 0, a);
    cycle(1, 5'd3, 32'h33, 0, 0, a);
    cycle(0, 5'd0, 32'h0, 0, 0, a);
    cycle(1, 5'd4, 32'h44, 1, 0, a);
    cycle(1, 5'd6, 32'h66, 1, 0, a);
    cycle(0, 5'd0, 32'h0, 1, 1, a);
    repeat (3) cycle(0, 5'd0, 32'h0, 0, 0, a);
    have = 1'b0;
    ridx = '0;
    rdat = '0;
    for (int i = 0; i < 600; i++) begin
      if (!have && $urandom_range(0, 3) != 0) begin
        have = 1'b1;
        ridx = 5'($urandom_range(0, 31));
        rdat = $urandom;
      end
      cycle(have, ridx, rdat, $urandom_range(0, 3) == 0, i % 150 == 149, a);
      if (a) have = 1'b0;
    end
    repeat (4) cycle(0, 5'd0, 32'h0, 0, 0, a);
    @(negedge clock);
    chk("scoreboard_drained", 1024'(expq.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
